ps2_tx_arbiter: RTL and testbench
=================================

# ps2_tx_arbiter

Arbitrates the shared PS/2 host transmitter between two command requesters: requester 0 is the mouse master state machine and requester 1 is the processor bus command port. The block sequences each transaction:
- grant,
- one-cycle send strobe to the transmitter,
- wait for transmit completion,
- capture and classify the device's response byte, with timeout.

It sits between the requesters and the transmitter/receiver pair and is the only driver of `SEND_BYTE`/`BYTE_TO_SEND`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 5000000: cycles allowed from the send strobe to the response byte (100 ms at 50 MHz). Counter width is `$clog2(ACK_TIMEOUT)`. Minimum value 4.
- `ACK_BYTE`, default 8'hFA: response byte classified as success.

Ports:
- `CLK` in 1: clock.
- `RESET` in 1: synchronous, active-high reset.
- `REQ0`, `REQ1` in 1 each: level request. Held high with the matching `BYTEx` stable until `DONEx`.
- `BYTE0`, `BYTE1` in 8 each: command byte of each requester.
- `DONE0`, `DONE1` out 1 each: one-cycle completion pulse to the owning requester.
- `STATUS` out 2: transaction result, valid while `DONEx` is high and held until the next grant.
- `RESP_BYTE` out 8: response byte captured in the last transaction. Held.
- `GRANT` out 2: one-hot current owner. 00 when idle.
- `BUSY` out 1: high in every state except IDLE.
- `SEND_BYTE` out 1: one-cycle strobe to the transmitter.
- `BYTE_TO_SEND` out 8: registered command byte, stable from the strobe until DONE.
- `BYTE_SENT` in 1: transmitter completion pulse.
- `READ_ENABLE` out 1: receiver enable, high in WAIT_RESP only.
- `BYTE_READY` in 1: receiver byte-valid pulse.
- `BYTE_READ` in 8: received byte.
- `BYTE_ERROR_CODE` in 2: receiver error. Nonzero means parity or framing error.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE.
- **Arbitration**
  - Round-robin, sampled in IDLE only.
  - A single requester is granted directly.
  - When both requesters are high, the one not granted last wins.
  - Reset sets last-grant to requester 1, so requester 0 wins the first contention.
- **IDLE → SEND** on any request:
  - latch `GRANT` and `BYTE_TO_SEND`;
  - update last-grant;
  - clear the timeout counter.
- **SEND**:
  - `SEND_BYTE`=1 for exactly one cycle;
  - go to WAIT_SENT;
  - the counter starts.
- **WAIT_SENT**:
  - on `BYTE_SENT`, go to WAIT_RESP;
  - `BYTE_READY` in this state is ignored.
- **WAIT_RESP**: `READ_ENABLE`=1. On `BYTE_READY`:
  - capture `BYTE_READ` into `RESP_BYTE`;
  - set `STATUS`: 11 if `BYTE_ERROR_CODE`≠0; else 00 if the byte equals `ACK_BYTE`; else 01 (e.g. FE resend, FC error);
  - go to DONE.
- **Timeout**:
  - the counter runs through WAIT_SENT and WAIT_RESP;
  - reaching `ACK_TIMEOUT-1` forces `STATUS`=10 and DONE;
  - `RESP_BYTE` is unchanged.
- **DONE**:
  - `DONEx` for the granted requester is 1 for one cycle;
  - `GRANT` clears on exit;
  - go to IDLE.
- **Requester rule**: the requester drops `REQx` at the edge after seeing `DONEx`. IDLE therefore never re-grants a stale request.
- **REQ drop mid-transaction**: a requester dropping `REQx` mid-transaction does not abort it. The transaction completes and `DONEx` still pulses.
- **`BYTEx` changes after grant**: ignored, because the byte is latched.

## Timing
- **Reset values**:
  - `SEND_BYTE`, `READ_ENABLE`, `DONE0`, `DONE1`, `BUSY` = 0;
  - `GRANT`, `STATUS` = 00;
  - `BYTE_TO_SEND`, `RESP_BYTE` = 8'h00;
  - state = IDLE;
  - counter = 0.
- **Reset mid-transaction**:
  - all of the above at the next edge;
  - no `DONE` pulse;
  - the pending request is re-arbitrated afterwards.
- **Request to strobe**: `REQx` high at edge k (IDLE) → `SEND_BYTE` high during cycle k+1.
- **Transmit to receive**: `BYTE_SENT` at edge m → `READ_ENABLE` high from cycle m+1.
- **Response to done**: `BYTE_READY` at edge r → `DONEx` and `STATUS` valid in cycle r+1, `BUSY` low from cycle r+2.
- **Simultaneous events**:
  - `BYTE_READY` with timeout in the same cycle: `BYTE_READY` wins, result is classified normally.
  - `BYTE_SENT` with timeout in the same cycle: timeout wins.
- **Back-to-back**: minimum 5 cycles per transaction, with 1 idle cycle between grants.

## Test plan
- **Single request, ACK**:
  - stimulus: `REQ0` with 8'hF4; `BYTE_SENT` 10 cycles after the strobe; `BYTE_READY` with 8'hFA;
  - required: `SEND_BYTE` pulses once with `BYTE_TO_SEND`=F4; then `DONE0`, `STATUS`=00, `RESP_BYTE`=FA, `DONE1` never pulses.
- **Contention**:
  - stimulus: `REQ0`=`REQ1` asserted in the same cycle, repeated three times;
  - required: grants go 0, 1, 0 (`GRANT`=01, 10, 01).
- **Non-ACK / error**:
  - stimulus: response 8'hFE, then response 8'hFA with `BYTE_ERROR_CODE`=01;
  - required: `STATUS`=01 with `RESP_BYTE`=FE, then `STATUS`=11.
- **Timeout** (`ACK_TIMEOUT`=16):
  - stimulus: `BYTE_SENT` arrives but no `BYTE_READY`;
  - required: `DONEx` exactly 16 cycles after the strobe cycle, `STATUS`=10; `BYTE_READY` on the timeout cycle yields `STATUS`=00.
- **Reset during WAIT_RESP**:
  - required: all outputs at reset values next cycle, no `DONE` pulse;
  - held `REQ1` is then re-granted with a fresh strobe.
- **Stray pulses**:
  - stimulus: `BYTE_READY` during IDLE or WAIT_SENT; `BYTE_SENT` during IDLE;
  - required: no state change; `RESP_BYTE` unchanged.

Source files
------------

// File: rtl/ps2_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ps2_tx_arbiter_if
// Groups every non-clock, non-reset signal of the PS/2 transmit arbiter.
//   Requester side : REQ0/REQ1, BYTE0/BYTE1 in; DONE0/DONE1, STATUS,
//                    RESP_BYTE, GRANT, BUSY out.
//   Transmitter    : SEND_BYTE, BYTE_TO_SEND out; BYTE_SENT in.
//   Receiver       : READ_ENABLE out; BYTE_READY, BYTE_READ,
//                    BYTE_ERROR_CODE in.
// The 'slave' modport is the arbiter's view. The 'master' modport is the
// view of everything around it: the requesters and the PHY pair.
// ---------------------------------------------------------------------------
interface ps2_tx_arbiter_if;
    logic       REQ0;
    logic       REQ1;
    logic [7:0] BYTE0;
    logic [7:0] BYTE1;
    logic       DONE0;
    logic       DONE1;
    logic [1:0] STATUS;
    logic [7:0] RESP_BYTE;
    logic [1:0] GRANT;
    logic       BUSY;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic       BYTE_READY;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;

    modport slave (
        input  REQ0, REQ1, BYTE0, BYTE1, BYTE_SENT,
               BYTE_READY, BYTE_READ, BYTE_ERROR_CODE,
        output DONE0, DONE1, STATUS, RESP_BYTE, GRANT, BUSY,
               SEND_BYTE, BYTE_TO_SEND, READ_ENABLE
    );

    modport master (
        output REQ0, REQ1, BYTE0, BYTE1, BYTE_SENT,
               BYTE_READY, BYTE_READ, BYTE_ERROR_CODE,
        input  DONE0, DONE1, STATUS, RESP_BYTE, GRANT, BUSY,
               SEND_BYTE, BYTE_TO_SEND, READ_ENABLE
    );
endinterface

// File: rtl/ps2_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ps2_tx_arbiter
// Shares one PS/2 host transmitter between two requesters: requester 0 is
// the mouse state machine and requester 1 is the CPU command port. For each
// transaction the block does the following:
//   1. grants the bus round-robin,
//   2. strobes the command byte into the transmitter,
//   3. waits for transmit completion,
//   4. captures and classifies the device response, under a timeout.
// Ports:
//   CLK    : clock
//   RESET  : synchronous, active-high reset
//   bus    : ps2_tx_arbiter_if.slave (requester, transmitter and receiver
//            signals)
// STATUS encoding:
//   00 = ACK_BYTE received
//   01 = a different byte received
//   10 = timeout
//   11 = receiver parity or framing error
// ---------------------------------------------------------------------------
module ps2_tx_arbiter #(
    parameter int         ACK_TIMEOUT = 5000000,
    parameter logic [7:0] ACK_BYTE    = 8'hFA
) (
    input  logic             CLK,
    input  logic             RESET,
    ps2_tx_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_SENT = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [1:0] STAT_ACK     = 2'b00;
    localparam logic [1:0] STAT_NACK    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_RXERR   = 2'b11;

    logic [2:0]       state_q,  state_d;
    logic [1:0]       grant_q,  grant_d;
    logic             last_q,   last_d;    // 1 = requester 1 was granted last
    logic [7:0]       byte_q,   byte_d;
    logic [7:0]       resp_q,   resp_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             timeout;

    // The counter is cleared on grant and counts from the strobe cycle.
    // With cnt == ACK_TIMEOUT-1 the timeout fires, so DONE lands exactly
    // ACK_TIMEOUT cycles after the strobe.
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        byte_d   = byte_q;
        resp_d   = resp_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    // Requester 0 wins when it is alone or when 1 went last.
                    if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
                        grant_d = 2'b01;
                        last_d  = 1'b0;
                        byte_d  = bus.BYTE0;
                    end else begin
                        grant_d = 2'b10;
                        last_d  = 1'b1;
                        byte_d  = bus.BYTE1;
                    end
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout outranks a late BYTE_SENT; BYTE_READY is ignored here.
                if (timeout) begin
                    status_d = STAT_TIMEOUT;
                    state_d  = ST_DONE;
                end else if (bus.BYTE_SENT) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the timeout cycle still counts.
                if (bus.BYTE_READY) begin
                    resp_d = bus.BYTE_READ;
                    if (bus.BYTE_ERROR_CODE != 2'b00)
                        status_d = STAT_RXERR;
                    else if (bus.BYTE_READ == ACK_BYTE)
                        status_d = STAT_ACK;
                    else
                        status_d = STAT_NACK;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    status_d = STAT_TIMEOUT;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            byte_q   <= 8'h00;
            resp_q   <= 8'h00;
            status_q <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            byte_q   <= byte_d;
            resp_q   <= resp_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    // All outputs decode directly from registered state, so they are glitch-free.
    assign bus.SEND_BYTE    = (state_q == ST_SEND);
    assign bus.READ_ENABLE  = (state_q == ST_WAIT_RESP);
    assign bus.BUSY         = (state_q != ST_IDLE);
    assign bus.DONE0        = (state_q == ST_DONE) && grant_q[0];
    assign bus.DONE1        = (state_q == ST_DONE) && grant_q[1];
    assign bus.GRANT        = grant_q;
    assign bus.BYTE_TO_SEND = byte_q;
    assign bus.RESP_BYTE    = resp_q;
    assign bus.STATUS       = status_q;
endmodule

// File: tb/tb_ps2_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx_arbiter
// Directed bench for ps2_tx_arbiter with ACK_TIMEOUT=16. Each scenario task
// drives the interface and compares outputs #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_ps2_tx_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   send_pulses = 0;
    int   done0_pulses = 0;
    int   done1_pulses = 0;

    ps2_tx_arbiter_if bus();

    ps2_tx_arbiter #(.ACK_TIMEOUT(16), .ACK_BYTE(8'hFA)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.SEND_BYTE) send_pulses  <= send_pulses + 1;
        if (bus.DONE0)     done0_pulses <= done0_pulses + 1;
        if (bus.DONE1)     done1_pulses <= done1_pulses + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.BYTE0 = 8'h00; bus.BYTE1 = 8'h00;
        bus.BYTE_SENT = 1'b0; bus.BYTE_READY = 1'b0;
        bus.BYTE_READ = 8'h00; bus.BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Run one full transaction with minimum latency from IDLE back to IDLE.
    // The caller compares the values it returns.
    task automatic do_txn(input logic r0, input logic r1, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] resp,
                          input logic [1:0] err, output logic [1:0] g,
                          output logic [7:0] sent, output logic [1:0] done_v,
                          output logic [1:0] st, output logic [7:0] rb);
        bus.REQ0 = r0; bus.REQ1 = r1; bus.BYTE0 = b0; bus.BYTE1 = b1;
        step();                                   // SEND
        g = bus.GRANT; sent = bus.BYTE_TO_SEND;
        step();                                   // WAIT_SENT
        bus.BYTE_SENT = 1'b1;
        step();                                   // WAIT_RESP
        bus.BYTE_SENT = 1'b0;
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = resp; bus.BYTE_ERROR_CODE = err;
        step();                                   // DONE
        done_v = {bus.DONE1, bus.DONE0}; st = bus.STATUS; rb = bus.RESP_BYTE;
        bus.BYTE_READY = 1'b0; bus.BYTE_ERROR_CODE = 2'b00;
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        step();                                   // IDLE
    endtask

    task automatic test_reset();
        clear_inputs();
        apply_reset();
        checks++;
        if ({bus.SEND_BYTE, bus.READ_ENABLE, bus.DONE0, bus.DONE1, bus.BUSY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.SEND_BYTE, bus.READ_ENABLE, bus.DONE0, bus.DONE1, bus.BUSY});
        end
        checks++;
        if ({bus.GRANT, bus.STATUS} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant_status: got %b want 0000", {bus.GRANT, bus.STATUS});
        end
        checks++;
        if ({bus.BYTE_TO_SEND, bus.RESP_BYTE} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bytes: got %h want 0000", {bus.BYTE_TO_SEND, bus.RESP_BYTE});
        end
        $display("test_reset done");
    endtask

    task automatic test_contention();
        logic [1:0] g, dv, st;
        logic [7:0] sent, rb;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_txn(1'b1, 1'b1, 8'hE8, 8'hF3, 8'hFA, 2'b00, g, sent, dv, st, rb);
            checks++;
            if (g !== exp_g[i]) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, g, exp_g[i]);
            end
            checks++;
            if (dv !== exp_g[i] || sent !== ((exp_g[i] == 2'b01) ? 8'hE8 : 8'hF3)) begin
                errors++;
                $display("FAIL contention_done[%0d]: done %b byte %h want done %b", i, dv, sent, exp_g[i]);
            end
            $display("contention txn %0d: grant=%b done=%b byte=%h", i, g, dv, sent);
        end
    endtask

    task automatic test_single_ack();
        int s0, d1;
        s0 = send_pulses; d1 = done1_pulses;
        bus.REQ0 = 1'b1; bus.BYTE0 = 8'hF4;
        step();                                   // strobe cycle s
        checks++;
        if (bus.SEND_BYTE !== 1'b1 || bus.BYTE_TO_SEND !== 8'hF4 || bus.GRANT !== 2'b01) begin
            errors++;
            $display("FAIL single_strobe: send %b byte %h grant %b want 1 f4 01",
                     bus.SEND_BYTE, bus.BYTE_TO_SEND, bus.GRANT);
        end
        bus.BYTE0 = 8'h00;                        // must be ignored now
        for (int i = 0; i < 10; i++) step();      // cycle s+10
        bus.BYTE_SENT = 1'b1;
        step();                                   // s+11
        bus.BYTE_SENT = 1'b0;
        checks++;
        if (bus.READ_ENABLE !== 1'b1 || bus.BYTE_TO_SEND !== 8'hF4) begin
            errors++;
            $display("FAIL single_read_enable: re %b byte %h want 1 f4", bus.READ_ENABLE, bus.BYTE_TO_SEND);
        end
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'hFA;
        step();                                   // DONE
        bus.BYTE_READY = 1'b0;
        checks++;
        if ({bus.DONE0, bus.DONE1, bus.STATUS, bus.RESP_BYTE} !== {1'b1, 1'b0, 2'b00, 8'hFA}) begin
            errors++;
            $display("FAIL single_done: done0 %b done1 %b status %b resp %h want 1 0 00 fa",
                     bus.DONE0, bus.DONE1, bus.STATUS, bus.RESP_BYTE);
        end
        bus.REQ0 = 1'b0;
        step();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.GRANT !== 2'b00 || bus.DONE0 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy %b grant %b done0 %b want 0 00 0", bus.BUSY, bus.GRANT, bus.DONE0);
        end
        checks++;
        if (send_pulses - s0 != 1 || done1_pulses != d1) begin
            errors++;
            $display("FAIL single_pulse_count: send %0d done1 %0d want 1 0", send_pulses - s0, done1_pulses - d1);
        end
        $display("test_single_ack done");
    endtask

    task automatic test_non_ack();
        logic [1:0] g, dv, st;
        logic [7:0] sent, rb;
        do_txn(1'b1, 1'b0, 8'hF2, 8'h00, 8'hFE, 2'b00, g, sent, dv, st, rb);
        checks++;
        if (st !== 2'b01 || rb !== 8'hFE || dv !== 2'b01) begin
            errors++;
            $display("FAIL nack_fe: status %b resp %h done %b want 01 fe 01", st, rb, dv);
        end
        $display("non_ack txn: status=%b resp=%h", st, rb);
        do_txn(1'b0, 1'b1, 8'h00, 8'hFF, 8'hFA, 2'b01, g, sent, dv, st, rb);
        checks++;
        if (st !== 2'b11 || rb !== 8'hFA || dv !== 2'b10) begin
            errors++;
            $display("FAIL rx_error: status %b resp %h done %b want 11 fa 10", st, rb, dv);
        end
        $display("rx_error txn: status=%b resp=%h", st, rb);
    endtask

    task automatic test_timeout();
        logic [7:0] prev;
        // Case 1: sent but no response. REQ1 drops mid-transaction.
        prev = bus.RESP_BYTE;
        bus.REQ1 = 1'b1; bus.BYTE1 = 8'hED;
        step();                                   // s
        step();                                   // s+1
        bus.BYTE_SENT = 1'b1;
        step();                                   // s+2
        bus.BYTE_SENT = 1'b0;
        step();                                   // s+3
        bus.REQ1 = 1'b0;
        for (int i = 0; i < 12; i++) step();      // s+15
        checks++;
        if (bus.DONE1 !== 1'b0 || bus.READ_ENABLE !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: done1 %b re %b at s+15 want 0 1", bus.DONE1, bus.READ_ENABLE);
        end
        step();                                   // s+16
        checks++;
        if (bus.DONE1 !== 1'b1 || bus.STATUS !== 2'b10 || bus.RESP_BYTE !== prev) begin
            errors++;
            $display("FAIL timeout_resp: done1 %b status %b resp %h want 1 10 %h",
                     bus.DONE1, bus.STATUS, bus.RESP_BYTE, prev);
        end
        step();
        $display("timeout txn 1: status=10 expected");
        // Case 2: BYTE_READY on the timeout cycle wins.
        bus.REQ0 = 1'b1; bus.BYTE0 = 8'hF4;
        step();                                   // s
        step();                                   // s+1
        bus.BYTE_SENT = 1'b1;
        step();                                   // s+2
        bus.BYTE_SENT = 1'b0;
        for (int i = 0; i < 13; i++) step();      // s+15
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'hFA;
        step();                                   // s+16
        bus.BYTE_READY = 1'b0;
        checks++;
        if (bus.DONE0 !== 1'b1 || bus.STATUS !== 2'b00 || bus.RESP_BYTE !== 8'hFA) begin
            errors++;
            $display("FAIL timeout_ready_wins: done0 %b status %b resp %h want 1 00 fa",
                     bus.DONE0, bus.STATUS, bus.RESP_BYTE);
        end
        bus.REQ0 = 1'b0;
        step();
        $display("timeout txn 2: ready on timeout cycle");
        // Case 3: BYTE_SENT on the timeout cycle loses.
        bus.REQ0 = 1'b1; bus.BYTE0 = 8'hF5;
        step();                                   // s
        for (int i = 0; i < 15; i++) step();      // s+15
        bus.BYTE_SENT = 1'b1;
        step();                                   // s+16
        bus.BYTE_SENT = 1'b0;
        checks++;
        if (bus.DONE0 !== 1'b1 || bus.STATUS !== 2'b10 || bus.READ_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sent_loses: done0 %b status %b re %b want 1 10 0",
                     bus.DONE0, bus.STATUS, bus.READ_ENABLE);
        end
        bus.REQ0 = 1'b0;
        step();
        $display("timeout txn 3: sent on timeout cycle");
    endtask

    task automatic test_reset_mid();
        int d0, d1;
        bus.REQ1 = 1'b1; bus.BYTE1 = 8'h5A;
        step();                                   // SEND
        step();                                   // WAIT_SENT
        bus.BYTE_SENT = 1'b1;
        step();                                   // WAIT_RESP
        bus.BYTE_SENT = 1'b0;
        d0 = done0_pulses; d1 = done1_pulses;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.BUSY, bus.READ_ENABLE, bus.DONE1, bus.GRANT, bus.STATUS} !== 7'b0 ||
            {bus.BYTE_TO_SEND, bus.RESP_BYTE} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy %b re %b done1 %b grant %b status %b tx %h resp %h want all zero",
                     bus.BUSY, bus.READ_ENABLE, bus.DONE1, bus.GRANT, bus.STATUS, bus.BYTE_TO_SEND, bus.RESP_BYTE);
        end
        step();                                   // re-granted: SEND
        checks++;
        if (bus.SEND_BYTE !== 1'b1 || bus.GRANT !== 2'b10 || bus.BYTE_TO_SEND !== 8'h5A) begin
            errors++;
            $display("FAIL reset_mid_regrant: send %b grant %b byte %h want 1 10 5a",
                     bus.SEND_BYTE, bus.GRANT, bus.BYTE_TO_SEND);
        end
        checks++;
        if (done0_pulses != d0 || done1_pulses != d1) begin
            errors++;
            $display("FAIL reset_mid_no_done: done pulses %0d/%0d want 0/0", done0_pulses - d0, done1_pulses - d1);
        end
        step();
        bus.BYTE_SENT = 1'b1;
        step();
        bus.BYTE_SENT = 1'b0; bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'hFA;
        step();                                   // DONE
        bus.BYTE_READY = 1'b0;
        checks++;
        if (bus.DONE1 !== 1'b1 || bus.STATUS !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_complete: done1 %b status %b want 1 00", bus.DONE1, bus.STATUS);
        end
        bus.REQ1 = 1'b0;
        step();
        $display("test_reset_mid done");
    endtask

    task automatic test_stray();
        logic [7:0] prev;
        prev = bus.RESP_BYTE;
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'h33; bus.BYTE_SENT = 1'b1;
        step();
        bus.BYTE_READY = 1'b0; bus.BYTE_SENT = 1'b0;
        step();
        checks++;
        if (bus.BUSY !== 1'b0 || bus.GRANT !== 2'b00 || bus.RESP_BYTE !== prev) begin
            errors++;
            $display("FAIL stray_idle: busy %b grant %b resp %h want 0 00 %h", bus.BUSY, bus.GRANT, bus.RESP_BYTE, prev);
        end
        bus.REQ0 = 1'b1; bus.BYTE0 = 8'h11;
        step();                                   // SEND
        step();                                   // WAIT_SENT
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'h44;
        step();                                   // still WAIT_SENT
        bus.BYTE_READY = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b1 || bus.READ_ENABLE !== 1'b0 || bus.DONE0 !== 1'b0 || bus.RESP_BYTE !== prev) begin
            errors++;
            $display("FAIL stray_wait_sent: busy %b re %b done0 %b resp %h want 1 0 0 %h",
                     bus.BUSY, bus.READ_ENABLE, bus.DONE0, bus.RESP_BYTE, prev);
        end
        bus.BYTE_SENT = 1'b1;
        step();                                   // WAIT_RESP
        bus.BYTE_SENT = 1'b0;
        bus.BYTE_READY = 1'b1; bus.BYTE_READ = 8'hFC;
        step();                                   // DONE
        bus.BYTE_READY = 1'b0;
        checks++;
        if (bus.DONE0 !== 1'b1 || bus.STATUS !== 2'b01 || bus.RESP_BYTE !== 8'hFC) begin
            errors++;
            $display("FAIL stray_then_resp: done0 %b status %b resp %h want 1 01 fc",
                     bus.DONE0, bus.STATUS, bus.RESP_BYTE);
        end
        bus.REQ0 = 1'b0;
        step();
        $display("test_stray done");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_contention();
        test_single_ack();
        test_non_ack();
        test_timeout();
        test_reset_mid();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
